clk_en_sched: RTL
=================

CLK_EN_SCHED -- requirements
Module: clk_en_sched

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of period/high/phase counters.
REQ-002 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port en  input  1  global run enable for both channels.
REQ-005 SHALL have port cfg_valid  input  1  config write request.
REQ-006 SHALL have port cfg_ready  output  1  config write can be accepted for channel cfg_ch.
REQ-007 SHALL have port cfg_ch  input  1  target channel (0 or 1).
REQ-008 SHALL have port cfg_period  input  CNT_W  period in clk cycles; 0 = channel disabled.
REQ-009 SHALL have port cfg_high  input  CNT_W  high time in clk cycles.
REQ-010 SHALL have port cfg_phase  input  CNT_W  start delay in clk cycles; present only with PHASE_OFFSET_EN.
REQ-011 SHALL have ports out0, out1  output  1 each  scheduled enable/clock-like waveforms.
REQ-012 SHALL have ports tick0, tick1  output  1 each  one-cycle pulse at each period start.
REQ-013 SHALL have port busy  output  1  high while any channel is in RUN (or PHASE).

Function
REQ-014 SHALL accept a config write on the cycle cfg_valid && cfg_ready; cfg_ready SHALL be combinational ~pending[cfg_ch].
REQ-015 SHALL store an accepted write in the channel's shadow register and set pending[ch].
REQ-016 SHALL per channel implement states IDLE, PHASE (macro only), RUN.
REQ-017 SHALL, in IDLE, copy shadow to active and clear pending on the cycle after acceptance.
REQ-018 SHALL move IDLE->RUN (or PHASE) when en=1 and active period != 0; cnt starts at 0.
REQ-019 SHALL, in RUN, count cnt 0..period-1 and wrap to 0; out = (cnt < high), registered, zero extra latency relative to cnt.
REQ-020 SHALL assert tick for one cycle whenever cnt == 0 in RUN.
REQ-021 SHALL, in RUN with pending set, load shadow to active at wrap (cnt == period-1), clear pending, start new period at cnt 0 next cycle.
REQ-022 SHALL hold out constantly high when high >= period, constantly low when high == 0 (tick still pulses).
REQ-023 SHALL, when a loaded period is 0, go RUN->IDLE at that wrap with out low.
REQ-024 SHALL, on en deassert, go to IDLE next cycle, clear cnt, drive out and tick low; pending writes are retained.
REQ-025 SHALL treat both channels independently; simultaneous boundary events on both channels SHALL both complete in the same cycle.
REQ-026 SHALL drive busy = OR of channels not in IDLE.

Reset
REQ-027 SHALL, when rst=1 at a rising edge, force both channels to IDLE, cnt=0, active and shadow registers=0, pending=0, out0=out1=tick0=tick1=busy=0.
REQ-028 SHALL give cfg_ready=1 the first cycle after reset; rst SHALL override every in-flight operation including mid-period and pending updates.

Configuration
REQ-029 SHALL compile PHASE_OFFSET_EN in or out via macro PHASE_OFFSET_EN.
REQ-030 SHALL, with PHASE_OFFSET_EN defined, enter PHASE from IDLE, hold out low for phase cycles, then enter RUN; phase 0 skips PHASE; phase is applied only on IDLE exit, not on in-run updates.
REQ-031 SHALL, without PHASE_OFFSET_EN, omit cfg_phase port and PHASE state; IDLE goes directly to RUN.

Verification
REQ-032 SHALL cover: ch0 period=2 high=1, en=1 -> out0 toggles every cycle, tick0 every 2nd cycle.
REQ-033 SHALL cover: ch1 period=4 high=2 -> out1 pattern 1,1,0,0 repeating; tick1 every 4 cycles; busy=1.
REQ-034 SHALL cover: ch1 running period=4, write period=8 high=2 mid-period -> cfg_ready low for ch1 until wrap; new pattern starts exactly at next cnt 0.
REQ-035 SHALL cover: en dropped at cnt=1 -> out0/out1 low next cycle, busy=0; en reasserted -> restart at cnt 0.
REQ-036 SHALL cover: rst pulsed mid-run with pending write -> all outputs 0, pending cleared, cfg_ready=1 next cycle.
REQ-037 SHALL cover (PHASE_OFFSET_EN): ch0 period=2 high=1 phase=1 -> out0 low one cycle after en, then toggles; first tick0 one cycle late.

Source files
------------

// File: rtl/clk_en_sched.sv
// Two-channel clock-enable scheduler: per-channel period/high waveform with tick pulses,
// shadowed config updates at period boundaries. Optional start delay via macro PHASE_OFFSET_EN.
module clk_en_sched #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic             cfg_ch,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_high,
`ifdef PHASE_OFFSET_EN
    input  logic [CNT_W-1:0] cfg_phase,
`endif
    output logic             out0,
    output logic             out1,
    output logic             tick0,
    output logic             tick1,
    output logic             busy
);

`ifdef PHASE_OFFSET_EN
    typedef enum logic [1:0] {IDLE = 2'd0, PHASE = 2'd1, RUN = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd2} state_t;
`endif

    localparam logic [CNT_W-1:0] ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    state_t           state_r   [2];
    state_t           state_s   [2];
    logic [CNT_W-1:0] cnt_r     [2];
    logic [CNT_W-1:0] cnt_s     [2];
    logic [CNT_W-1:0] per_r     [2];
    logic [CNT_W-1:0] per_s     [2];
    logic [CNT_W-1:0] high_r    [2];
    logic [CNT_W-1:0] high_s    [2];
    logic [CNT_W-1:0] sh_per_r  [2];
    logic [CNT_W-1:0] sh_high_r [2];
`ifdef PHASE_OFFSET_EN
    logic [CNT_W-1:0] ph_r      [2];
    logic [CNT_W-1:0] ph_s      [2];
    logic [CNT_W-1:0] sh_ph_r   [2];
`endif
    logic [1:0]       pend_r;
    logic [1:0]       pend_s;
    logic [1:0]       load_s;
    logic [1:0]       out_r;
    logic [1:0]       out_s;
    logic [1:0]       tick_r;
    logic [1:0]       tick_s;
    logic             busy_r;
    logic             busy_s;
    logic             accept_s;

    assign cfg_ready = ~pend_r[cfg_ch];
    assign accept_s  = cfg_valid & cfg_ready;

    assign out0  = out_r[0];
    assign out1  = out_r[1];
    assign tick0 = tick_r[0];
    assign tick1 = tick_r[1];
    assign busy  = busy_r;

    // Per-channel next-state, counter, config load and registered-output precompute
    always_comb begin
        for (int ch = 0; ch < 2; ch++) begin
            state_s[ch] = state_r[ch];
            cnt_s[ch]   = cnt_r[ch];
            per_s[ch]   = per_r[ch];
            high_s[ch]  = high_r[ch];
`ifdef PHASE_OFFSET_EN
            ph_s[ch]    = ph_r[ch];
`endif
            pend_s[ch]  = pend_r[ch];
            load_s[ch]  = 1'b0;
            case (state_r[ch])
                IDLE: begin
                    cnt_s[ch] = ZERO;
                    if (pend_r[ch]) begin
                        load_s[ch] = 1'b1;
                    end else if (en && (per_r[ch] != ZERO)) begin
`ifdef PHASE_OFFSET_EN
                        state_s[ch] = (ph_r[ch] != ZERO) ? PHASE : RUN;
`else
                        state_s[ch] = RUN;
`endif
                    end else begin
                        state_s[ch] = IDLE;
                    end
                end
`ifdef PHASE_OFFSET_EN
                PHASE: begin
                    if (!en) begin
                        state_s[ch] = IDLE;
                        cnt_s[ch]   = ZERO;
                    end else if (cnt_r[ch] == ph_r[ch] - ONE) begin
                        state_s[ch] = RUN;
                        cnt_s[ch]   = ZERO;
                    end else begin
                        cnt_s[ch]   = cnt_r[ch] + ONE;
                    end
                end
`endif
                RUN: begin
                    if (!en) begin
                        state_s[ch] = IDLE;
                        cnt_s[ch]   = ZERO;
                    end else if (cnt_r[ch] == per_r[ch] - ONE) begin
                        cnt_s[ch] = ZERO;
                        // Pending config takes effect exactly at the period boundary
                        if (pend_r[ch]) begin
                            load_s[ch]  = 1'b1;
                            state_s[ch] = (sh_per_r[ch] == ZERO) ? IDLE : RUN;
                        end else begin
                            state_s[ch] = RUN;
                        end
                    end else begin
                        cnt_s[ch] = cnt_r[ch] + ONE;
                    end
                end
                default: begin
                    state_s[ch] = IDLE;
                    cnt_s[ch]   = ZERO;
                end
            endcase
            if (load_s[ch]) begin
                per_s[ch]  = sh_per_r[ch];
                high_s[ch] = sh_high_r[ch];
`ifdef PHASE_OFFSET_EN
                ph_s[ch]   = sh_ph_r[ch];
`endif
                pend_s[ch] = 1'b0;
            end else begin
                pend_s[ch] = pend_r[ch];
            end
            if (accept_s && (cfg_ch == 1'(ch))) begin
                pend_s[ch] = 1'b1;
            end else begin
                pend_s[ch] = pend_s[ch];
            end
            out_s[ch]  = (state_s[ch] == RUN) && (cnt_s[ch] < high_s[ch]);
            tick_s[ch] = (state_s[ch] == RUN) && (cnt_s[ch] == ZERO);
        end
        busy_s = (state_s[0] != IDLE) || (state_s[1] != IDLE);
    end

    // State, counters, active/shadow config and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int ch = 0; ch < 2; ch++) begin
                state_r[ch]   <= IDLE;
                cnt_r[ch]     <= ZERO;
                per_r[ch]     <= ZERO;
                high_r[ch]    <= ZERO;
                sh_per_r[ch]  <= ZERO;
                sh_high_r[ch] <= ZERO;
`ifdef PHASE_OFFSET_EN
                ph_r[ch]      <= ZERO;
                sh_ph_r[ch]   <= ZERO;
`endif
            end
            pend_r <= 2'b00;
            out_r  <= 2'b00;
            tick_r <= 2'b00;
            busy_r <= 1'b0;
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                state_r[ch] <= state_s[ch];
                cnt_r[ch]   <= cnt_s[ch];
                per_r[ch]   <= per_s[ch];
                high_r[ch]  <= high_s[ch];
`ifdef PHASE_OFFSET_EN
                ph_r[ch]    <= ph_s[ch];
`endif
            end
            if (accept_s) begin
                sh_per_r[cfg_ch]  <= cfg_period;
                sh_high_r[cfg_ch] <= cfg_high;
`ifdef PHASE_OFFSET_EN
                sh_ph_r[cfg_ch]   <= cfg_phase;
`endif
            end
            pend_r <= pend_s;
            out_r  <= out_s;
            tick_r <= tick_s;
            busy_r <= busy_s;
        end
    end

endmodule
